// File: rtl/spi_reg_if_if.sv
// Register-file side of the SPI slave: address, write data/strobe out, read data back.
// reg_we is a one-clk strobe; reg_addr/reg_wdata are valid in that cycle and there is no back-pressure.
interface spi_reg_if_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wdata;
  logic              reg_we;
  logic [7:0]        reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    output reg_rdata
  );
endinterface

// File: rtl/spi_reg_if.sv
// Oversampled SPI mode-0 slave: 16-bit frames {rw, addr[6:0], data[7:0]} become
// single-cycle register writes or side-effect-free register reads.
module spi_reg_if #(
  parameter int ADDR_W      = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  spi_reg_if_if.master      bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
  logic                   sclk_d, cs_d;
  logic                   sclk_q, cs_q, mosi_q;
  logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [3:0] bit_cnt;
  logic [7:0] rx, rx_nx;
  logic [7:0] tx;
  logic       rw;

  // Pin synchronisers; cs_n resets to its inactive level so reset never looks like a select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s <= '0;
      cs_s   <= '1;
      mosi_s <= '0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      sclk_s <= {sclk_s[SYNC_STAGES-2:0], spi_sclk};
      cs_s   <= {cs_s[SYNC_STAGES-2:0], spi_cs_n};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], spi_mosi};
      sclk_d <= sclk_s[SYNC_STAGES-1];
      cs_d   <= cs_s[SYNC_STAGES-1];
    end
  end

  assign sclk_q    = sclk_s[SYNC_STAGES-1];
  assign cs_q      = cs_s[SYNC_STAGES-1];
  assign mosi_q    = mosi_s[SYNC_STAGES-1];
  assign sclk_rise = sclk_q & ~sclk_d;
  assign sclk_fall = ~sclk_q & sclk_d;
  assign cs_rise   = cs_q & ~cs_d;
  assign cs_fall   = ~cs_q & cs_d;
  assign rx_nx     = {rx[6:0], mosi_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Deselect wins over any sclk edge seen in the same cycle.
  always_comb begin
    state_nx = state;
    if (cs_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_nx = CMD;
        CMD:     if (sclk_rise && bit_cnt == 4'd7) state_nx = DATA;
        DATA:    if (sclk_rise && bit_cnt == 4'd15) state_nx = DRAIN;
        DRAIN:   state_nx = DRAIN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= 4'd0;
      rx            <= 8'd0;
      tx            <= 8'd0;
      rw            <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= 8'd0;
      bus.reg_we    <= 1'b0;
    end else begin
      bus.reg_we <= 1'b0;
      if (!cs_rise) begin
        if (state == IDLE) begin
          if (cs_fall) begin
            bit_cnt <= 4'd0;
            rx      <= 8'd0;
            tx      <= 8'd0;
          end
        end else if (state == CMD || state == DATA) begin
          if (sclk_rise) begin
            rx      <= rx_nx;
            bit_cnt <= bit_cnt + 4'd1;
            if (state == CMD && bit_cnt == 4'd7) begin
              rw           <= rx_nx[7];
              bus.reg_addr <= rx_nx[ADDR_W-1:0];
            end
            if (state == DATA && bit_cnt == 4'd15 && rw) begin
              bus.reg_wdata <= rx_nx;
              bus.reg_we    <= 1'b1;
            end
          end else if (sclk_fall && state == DATA) begin
            // The fall right after the command byte fetches read data exactly once.
            if (bit_cnt == 4'd8) begin
              if (!rw) tx <= bus.reg_rdata;
            end else begin
              tx <= {tx[6:0], 1'b0};
            end
          end
        end
      end
    end
  end

  assign spi_miso    = ((state == DATA || state == DRAIN) && !rw && !cs_q) ? tx[7] : 1'b0;
  assign spi_miso_oe = ~cs_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_spi_reg_if.sv
// Bench for spi_reg_if: frame-level reference model of the register file and of the
// expected write strobes, checked against the DUT every clock, plus directed frames.
module tb_spi_reg_if;
  localparam int ADDR_W = 5;
  localparam int WR_W   = 32 + ADDR_W + 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [1:0] dbg_state;

  spi_reg_if_if #(.ADDR_W(ADDR_W)) bus ();

  spi_reg_if #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .bus         (bus),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset / time base ----------------
  always #5 clk = ~clk;

  int         cyc = 0;
  logic [1:0] cs_hist = 2'b11;
  int         quiet = 3;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    cs_hist <= {cs_hist[0], spi_cs_n};
    if (!rst_n)         quiet <= 3;
    else if (quiet > 0) quiet <= quiet - 1;
  end

  // ---------------- register file seen by the DUT ----------------
  logic [7:0] rf_mem   [32];
  logic [7:0] model_rf [32];
  logic       load_rf = 1'b0;

  always @(posedge clk) begin
    if (load_rf) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= model_rf[i];
    end else if (bus.reg_we) begin
      rf_mem[bus.reg_addr] <= bus.reg_wdata;
    end
  end
  assign bus.reg_rdata = rf_mem[bus.reg_addr];

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [WR_W-1:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int   we_seen = 0;
  int   we_exp  = 0;
  logic chk_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: output enable follows cs_n two clocks late, miso is quiet while
  // deselected, and every write strobe matches the predicted cycle/address/data.
  always begin
    logic [WR_W-1:0] e;
    logic            e_oe;
    @(negedge clk);
    #2;
    if (chk_on) begin
      if (!rst_n) begin
        chk("rst_we", bus.reg_we, 0);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_miso", spi_miso, 0);
      end else begin
        if (quiet == 0) begin
          e_oe = ~cs_hist[1];
          chk("miso_oe", spi_miso_oe, e_oe);
          if (!e_oe) chk("miso_deselected", spi_miso, 0);
        end
        if (bus.reg_we) begin
          we_seen++;
          chk("we_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("we_cycle", cyc, e[WR_W-1 -: 32]);
            chk("we_addr", bus.reg_addr, e[ADDR_W+7:8]);
            chk("we_data", bus.reg_wdata, e[7:0]);
          end
        end else if (exp_q.size() > 0 && int'(exp_q[0][WR_W-1 -: 32]) < cyc) begin
          chk("we_missing", bus.reg_we, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver ----------------
  // word is left-justified: bit i of the frame is word[23-i].
  // kind 0: full frame; 1: cs_n raised after stop_at bits; 2: rst_n pulsed after stop_at bits.
  task automatic send_frame(input logic [23:0] word, input int nbits, input int kind,
                            input int stop_at, input int half, input int gap,
                            output logic [15:0] miso_bits);
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
    logic              rw;
    logic [31:0]       tc;
    cmd = word[23:16];
    rw  = cmd[7];
    a   = cmd[ADDR_W-1:0];
    d   = word[15:8];
    miso_bits = '0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (kind != 0 && i == stop_at) break;
      spi_mosi = word[23-i];
      repeat (half) @(negedge clk);
      if (i < 16) miso_bits[15-i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 7) exp_addr = a;
      if (i == 15 && rw) begin
        tc = cyc + 3;
        exp_q.push_back({tc, a, d});
        model_rf[a] = d;
        we_exp++;
      end
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
    if (kind == 2) begin
      rst_n = 1'b0;
      #1;
      chk("midrst_addr", bus.reg_addr, 0);
      chk("midrst_wdata", bus.reg_wdata, 0);
      chk("midrst_we", bus.reg_we, 0);
      chk("midrst_miso", spi_miso, 0);
      chk("midrst_oe", spi_miso_oe, 0);
      chk("midrst_state", dbg_state, 0);
      exp_addr = '0;
      repeat (2) @(negedge clk);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (gap) @(negedge clk);
    end else begin
      repeat (half) @(negedge clk);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (gap) @(negedge clk);
      if (kind == 0) begin
        chk("miso_cmd_byte", miso_bits[15:8], 0);
        if (rw) chk("miso_wr_byte", miso_bits[7:0], 0);
        else    chk("miso_rd_byte", miso_bits[7:0], model_rf[a]);
      end
      chk("addr_hold", bus.reg_addr, exp_addr);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] mb;
    int          w0;
    for (int i = 0; i < 32; i++) model_rf[i] = 8'($urandom_range(0, 255));
    model_rf[11] = 8'hC3;
    rst_n   = 1'b0;
    load_rf = 1'b1;
    repeat (3) @(negedge clk);
    load_rf = 1'b0;
    chk("reset_addr", bus.reg_addr, 0);
    chk("reset_wdata", bus.reg_wdata, 0);
    chk("reset_we", bus.reg_we, 0);
    chk("reset_miso", spi_miso, 0);
    chk("reset_oe", spi_miso_oe, 0);
    chk("reset_state", dbg_state, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_on = 1'b1;

    // Plain write at sclk = clk/8.
    w0 = we_seen;
    send_frame({16'h8A55, 8'h00}, 16, 0, 0, 4, 6, mb);
    chk("t1_we_count", we_seen - w0, 1);
    chk("t1_addr", bus.reg_addr, 5'h0A);
    chk("t1_wdata", bus.reg_wdata, 8'h55);

    // Read of 0x0B returns 0xC3 on miso bits 8..15.
    w0 = we_seen;
    send_frame({16'h0B00, 8'h00}, 16, 0, 0, 4, 6, mb);
    chk("t2_miso", mb[7:0], 8'hC3);
    chk("t2_we_count", we_seen - w0, 0);

    // Write aborted after 10 bits, then a normal write.
    w0 = we_seen;
    send_frame({16'h9FAA, 8'h00}, 16, 1, 10, 4, 6, mb);
    chk("t3_abort_we", we_seen - w0, 0);
    chk("t3_abort_addr", bus.reg_addr, 5'h1F);
    send_frame({16'h8101, 8'h00}, 16, 0, 0, 4, 6, mb);
    chk("t3_we_count", we_seen - w0, 1);
    chk("t3_addr", bus.reg_addr, 5'h01);
    chk("t3_wdata", bus.reg_wdata, 8'h01);

    // 24-bit burst: trailing byte ignored.
    w0 = we_seen;
    send_frame(24'h8412FF, 24, 0, 0, 4, 6, mb);
    chk("t4_we_count", we_seen - w0, 1);
    chk("t4_addr", bus.reg_addr, 5'h04);
    chk("t4_wdata", bus.reg_wdata, 8'h12);

    // Reset mid-write, then a full frame.
    w0 = we_seen;
    send_frame({16'h8C77, 8'h00}, 16, 2, 12, 4, 6, mb);
    chk("t5_rst_we", we_seen - w0, 0);
    send_frame({16'h8233, 8'h00}, 16, 0, 0, 4, 6, mb);
    chk("t5_we_count", we_seen - w0, 1);
    chk("t5_addr", bus.reg_addr, 5'h02);
    chk("t5_wdata", bus.reg_wdata, 8'h33);

    // Back-to-back writes with a 4-clk deselect gap.
    w0 = we_seen;
    send_frame({16'h8011, 8'h00}, 16, 0, 0, 4, 4, mb);
    chk("t6_first_wdata", bus.reg_wdata, 8'h11);
    send_frame({16'h8122, 8'h00}, 16, 0, 0, 4, 4, mb);
    chk("t6_we_count", we_seen - w0, 2);
    chk("t6_addr", bus.reg_addr, 5'h01);
    chk("t6_wdata", bus.reg_wdata, 8'h22);

    // Randomized frames: mixed reads/writes, lengths, aborts and sclk rates.
    for (int n = 0; n < 40; n++) begin
      logic [23:0] word;
      int          kind, stop_at, nbits;
      word    = 24'($urandom());
      nbits   = ($urandom_range(0, 3) == 0) ? 24 : 16;
      kind    = ($urandom_range(0, 7) == 0) ? 1 : 0;
      stop_at = $urandom_range(1, 15);
      send_frame(word, nbits, kind, stop_at, $urandom_range(4, 7), $urandom_range(4, 8), mb);
    end

    repeat (10) @(negedge clk);
    chk("exp_queue_empty", exp_q.size(), 0);
    chk("we_total", we_seen, we_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
